// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with the architectural NZCV flag register.
// flags_byp exposes next-edge flag values so a conditional branch in EX sees them early.
module ex_mem_reg #(
  parameter int WIDTH = 64,
  parameter int RBITS = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic [2:0]       ex_cntrl,
  input  logic [WIDTH-1:0] ex_result,
  input  logic             ex_cout,
  input  logic             ex_cin_msb,
  input  logic             ex_setflags,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic             ex_memwrite,
  input  logic [RBITS-1:0] ex_rd,
  input  logic [WIDTH-1:0] ex_store_data,
  output logic             mem_valid,
  output logic             mem_regwrite,
  output logic             mem_memread,
  output logic             mem_memwrite,
  output logic [WIDTH-1:0] mem_result,
  output logic [RBITS-1:0] mem_rd,
  output logic [WIDTH-1:0] mem_store_data,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic [3:0]       flags_byp
);

  // Pipeline control: flush turns the incoming slot into a bubble (data held) and
  // outranks stall; stall alone freezes everything; otherwise the stage advances.
  logic       advance;
  logic       flag_upd;
  logic [3:0] flags_q;
  logic [3:0] flags_nxt;

  assign advance  = !stall && !flush;
  assign flag_upd = advance && ex_valid && ex_setflags;

  // flags_q / flags_nxt are packed {N, Z, C, V}.
  always_comb begin
    flags_nxt    = flags_q;
    flags_nxt[3] = ex_result[WIDTH-1];
    flags_nxt[2] = (ex_result == '0);
    case (ex_cntrl)
      3'b010, 3'b011: begin
        flags_nxt[1] = ex_cout;
        flags_nxt[0] = ex_cout ^ ex_cin_msb;
      end
      3'b100, 3'b101, 3'b110: begin
        flags_nxt[1] = 1'b0;
        flags_nxt[0] = 1'b0;
      end
      default: ;  // pass-B and shift keep C and V
    endcase
  end

  assign flags_byp = flag_upd ? flags_nxt : flags_q;
  assign flag_n    = flags_q[3];
  assign flag_z    = flags_q[2];
  assign flag_c    = flags_q[1];
  assign flag_v    = flags_q[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_valid      <= 1'b0;
      mem_regwrite   <= 1'b0;
      mem_memread    <= 1'b0;
      mem_memwrite   <= 1'b0;
      mem_result     <= '0;
      mem_rd         <= '0;
      mem_store_data <= '0;
    end else if (flush) begin
      mem_valid      <= 1'b0;
      mem_regwrite   <= 1'b0;
      mem_memread    <= 1'b0;
      mem_memwrite   <= 1'b0;
    end else if (!stall) begin
      mem_valid      <= ex_valid;
      // writes to the zero register (index 31) are dropped here
      mem_regwrite   <= ex_regwrite && ex_valid && (ex_rd != RBITS'(31));
      mem_memread    <= ex_memread && ex_valid;
      mem_memwrite   <= ex_memwrite && ex_valid;
      mem_result     <= ex_result;
      mem_rd         <= ex_rd;
      mem_store_data <= ex_store_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      flags_q <= 4'b0000;
    else if (flag_upd)
      flags_q <= flags_nxt;
  end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed, table-driven bench for ex_mem_reg: per-vector bypass and registered checks,
// plus hand sequences for stall/flush interplay and asynchronous reset.
module tb_ex_mem_reg;

  localparam int W = 64;
  localparam int R = 5;
  localparam int PW = 4 + W + R + W + 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         stall, flush, ex_valid;
  logic [2:0]   ex_cntrl;
  logic [W-1:0] ex_result;
  logic         ex_cout, ex_cin_msb, ex_setflags, ex_regwrite, ex_memread, ex_memwrite;
  logic [R-1:0] ex_rd;
  logic [W-1:0] ex_store_data;
  logic         mem_valid, mem_regwrite, mem_memread, mem_memwrite;
  logic [W-1:0] mem_result, mem_store_data;
  logic [R-1:0] mem_rd;
  logic         flag_n, flag_z, flag_c, flag_v;
  logic [3:0]   flags_byp;

  ex_mem_reg #(.WIDTH(W), .RBITS(R)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_cntrl(ex_cntrl), .ex_result(ex_result),
    .ex_cout(ex_cout), .ex_cin_msb(ex_cin_msb), .ex_setflags(ex_setflags),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_rd(ex_rd), .ex_store_data(ex_store_data),
    .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite), .mem_result(mem_result), .mem_rd(mem_rd),
    .mem_store_data(mem_store_data), .flag_n(flag_n), .flag_z(flag_z),
    .flag_c(flag_c), .flag_v(flag_v), .flags_byp(flags_byp)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic         stall, flush, valid;
    logic [2:0]   cntrl;
    logic [W-1:0] result;
    logic         cout, cin, setflags, regwrite, memread, memwrite;
    logic [R-1:0] rd;
    logic [W-1:0] store;
    logic [3:0]   e_ctl;    // {valid, regwrite, memread, memwrite}
    logic [W-1:0] e_result;
    logic [R-1:0] e_rd;
    logic [W-1:0] e_store;
    logic [3:0]   e_flags;  // {N, Z, C, V}
    logic [3:0]   e_byp;
  } vec_t;

  localparam logic [W-1:0] MSB  = 64'h8000_0000_0000_0000;
  localparam logic [W-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  vec_t vecs [13];
  logic [PW-1:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard
  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] act_pack();
    return {mem_valid, mem_regwrite, mem_memread, mem_memwrite, mem_result, mem_rd,
            mem_store_data, flag_n, flag_z, flag_c, flag_v};
  endfunction

  function automatic logic [PW-1:0] exp_pack(input vec_t v);
    return {v.e_ctl, v.e_result, v.e_rd, v.e_store, v.e_flags};
  endfunction

  // driver tasks
  task automatic drive(input vec_t v);
    stall = v.stall; flush = v.flush; ex_valid = v.valid; ex_cntrl = v.cntrl;
    ex_result = v.result; ex_cout = v.cout; ex_cin_msb = v.cin;
    ex_setflags = v.setflags; ex_regwrite = v.regwrite; ex_memread = v.memread;
    ex_memwrite = v.memwrite; ex_rd = v.rd; ex_store_data = v.store;
  endtask

  task automatic apply(input string name, input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    check({name, "_byp"}, PW'(flags_byp), PW'(v.e_byp));
    exp_q.push_back(exp_pack(v));
    @(posedge clk);
    #1;
    check({name, "_out"}, act_pack(), exp_q.pop_front());
  endtask

  vec_t t;

  initial begin
    //          st fl v  cntrl   result     co ci sf rw mr mw rd     store       e_ctl   e_result   e_rd    e_store     e_flags e_byp
    vecs[0]  = '{0, 0, 1, 3'b010, 64'h0,     1, 1, 1, 1, 0, 0, 5'd3,  64'hAA,     4'b1100, 64'h0,     5'd3,  64'hAA,     4'b0110, 4'b0110};
    vecs[1]  = '{0, 0, 1, 3'b011, MSB,       0, 1, 1, 0, 0, 1, 5'd5,  64'h1234,   4'b1001, MSB,       5'd5,  64'h1234,   4'b1001, 4'b1001};
    vecs[2]  = '{0, 0, 1, 3'b010, 64'h7,     1, 0, 1, 1, 1, 0, 5'd7,  64'h0,      4'b1110, 64'h7,     5'd7,  64'h0,      4'b0011, 4'b0011};
    vecs[3]  = '{0, 0, 1, 3'b100, 64'h1,     1, 0, 1, 1, 0, 0, 5'd31, 64'h99,     4'b1000, 64'h1,     5'd31, 64'h99,     4'b0000, 4'b0000};
    vecs[4]  = '{0, 0, 1, 3'b010, 64'h10,    1, 1, 1, 0, 0, 0, 5'd2,  64'h0,      4'b1000, 64'h10,    5'd2,  64'h0,      4'b0010, 4'b0010};
    vecs[5]  = '{0, 0, 1, 3'b000, ONES,      0, 1, 1, 1, 0, 0, 5'd4,  64'h3,      4'b1100, ONES,      5'd4,  64'h3,      4'b1010, 4'b1010};
    vecs[6]  = '{0, 0, 1, 3'b111, 64'h0,     0, 0, 1, 1, 0, 0, 5'd6,  64'h4,      4'b1100, 64'h0,     5'd6,  64'h4,      4'b0110, 4'b0110};
    vecs[7]  = '{0, 0, 0, 3'b010, 64'h42,    0, 0, 1, 1, 1, 1, 5'd9,  64'h77,     4'b0000, 64'h42,    5'd9,  64'h77,     4'b0110, 4'b0110};
    vecs[8]  = '{0, 0, 1, 3'b110, 64'h0,     0, 0, 0, 1, 0, 0, 5'd0,  64'h8,      4'b1100, 64'h0,     5'd0,  64'h8,      4'b0110, 4'b0110};
    vecs[9]  = '{0, 0, 1, 3'b110, MSB,       0, 0, 1, 0, 1, 0, 5'd12, 64'h5,      4'b1010, MSB,       5'd12, 64'h5,      4'b1000, 4'b1000};
    vecs[10] = '{0, 1, 1, 3'b010, 64'h0,     1, 1, 1, 1, 1, 1, 5'd20, 64'hDEAD,   4'b0000, MSB,       5'd12, 64'h5,      4'b1000, 4'b1000};
    vecs[11] = '{1, 0, 1, 3'b100, 64'h3,     0, 0, 1, 1, 1, 1, 5'd21, 64'h6,      4'b0000, MSB,       5'd12, 64'h5,      4'b1000, 4'b1000};
    vecs[12] = '{0, 0, 1, 3'b101, 64'h55,    0, 0, 1, 1, 0, 0, 5'd1,  64'h66,     4'b1100, 64'h55,    5'd1,  64'h66,     4'b0000, 4'b0000};

    // reset state
    reset_n = 1'b0;
    t = '{0, 0, 0, 3'b000, 64'h0, 0, 0, 0, 0, 0, 0, 5'd0, 64'h0, 4'b0, 64'h0, 5'd0, 64'h0, 4'b0, 4'b0};
    drive(t);
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", act_pack(), '0);
    check("reset_byp", PW'(flags_byp), '0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++)
      apply($sformatf("row%0d", i), vecs[i]);

    // stall for three cycles with changing inputs that would set flags
    for (int i = 0; i < 3; i++) begin
      t = '{1, 0, 1, 3'b010, 64'h0, 1, 1, 1, 0, 1, 1, 5'd8, 64'hBB,
            4'b1100, 64'h55, 5'd1, 64'h66, 4'b0000, 4'b0000};
      t.result = 64'(i);
      apply($sformatf("stall%0d", i), t);
    end
    t = '{1, 1, 1, 3'b010, 64'h0, 1, 1, 1, 1, 1, 1, 5'd8, 64'hBB,
          4'b0000, 64'h55, 5'd1, 64'h66, 4'b0000, 4'b0000};
    apply("stall_flush", t);

    // asynchronous reset between edges while mem_valid=1
    t = '{0, 0, 1, 3'b010, 64'h0, 1, 1, 1, 1, 1, 1, 5'd10, 64'hCC,
          4'b1111, 64'h0, 5'd10, 64'hCC, 4'b0110, 4'b0110};
    apply("pre_reset", t);
    t = '{1, 1, 0, 3'b000, 64'h0, 0, 0, 0, 0, 0, 0, 5'd0, 64'h0, 4'b0, 64'h0, 5'd0, 64'h0, 4'b0, 4'b0};
    drive(t);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", act_pack(), '0);
    check("async_reset_byp", PW'(flags_byp), '0);
    t = '{0, 0, 1, 3'b010, 64'h0, 1, 1, 1, 1, 0, 0, 5'd2, 64'h0, 4'b0, 64'h0, 5'd0, 64'h0, 4'b0, 4'b0};
    drive(t);
    #1;
    check("reset_byp_pending", PW'(flags_byp), PW'(4'b0110));
    @(posedge clk);
    #1;
    check("reset_held_over_edge", act_pack(), '0);
    reset_n = 1'b1;
    t = '{0, 0, 1, 3'b011, MSB, 0, 1, 1, 1, 0, 0, 5'd13, 64'hEE,
          4'b1100, MSB, 5'd13, 64'hEE, 4'b1001, 4'b1001};
    apply("first_after_reset", t);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
- REQ-001: Parameter WIDTH, default 64, datapath width of the ALU result and store data.
- REQ-002: Parameter RBITS, default 5, register-index width.
- REQ-003: clk  input  1  single clock; all state updates on rising edge.
- REQ-004: reset_n  input  1  reset, asynchronous, active-low.
- REQ-005: stall  input  1  hold all state this cycle.
- REQ-006: flush  input  1  replace the incoming EX instruction with a bubble.
- REQ-007: ex_valid  input  1  EX stage holds a real instruction.
- REQ-008: ex_cntrl  input  3  ALU control code (000 pass B, 010 add, 011 sub, 100 and, 101 or, 110 xor, 111 shift).
- REQ-009: ex_result  input  WIDTH  ALU result.
- REQ-010: ex_cout  input  1  carry out of the MSB slice.
- REQ-011: ex_cin_msb  input  1  carry into the MSB slice.
- REQ-012: ex_setflags, ex_regwrite, ex_memread, ex_memwrite  input  1 each  EX control bits.
- REQ-013: ex_rd  input  RBITS  destination register index.
- REQ-014: ex_store_data  input  WIDTH  store operand.
- REQ-015: mem_valid, mem_regwrite, mem_memread, mem_memwrite  output  1 each  registered control.
- REQ-016: mem_result, mem_store_data  output  WIDTH; mem_rd  output  RBITS  registered data.
- REQ-017: flag_n, flag_z, flag_c, flag_v  output  1 each  architectural flag register.
- REQ-018: flags_byp  output  4  {N,Z,C,V} as they will be after this edge (combinational bypass for B.cond in EX).

Function
- REQ-019: Update ("advance") occurs on a rising edge with stall=0 and flush=0; all mem_* registers load from the corresponding ex_* inputs.
- REQ-020: Advance latency is exactly one cycle; no combinational path from ex_* to mem_*.
- REQ-021: mem_regwrite SHALL load ex_regwrite AND ex_valid AND (ex_rd != 31); mem_memread/mem_memwrite SHALL load their inputs AND ex_valid.
- REQ-022: flush=1 (regardless of stall) SHALL load mem_valid, mem_regwrite, mem_memread and mem_memwrite with 0; mem_result, mem_rd and mem_store_data hold; flags hold.
- REQ-023: stall=1 with flush=0 SHALL hold every register, flags included.
- REQ-024: Flags update only on advance with ex_valid=1 and ex_setflags=1; otherwise flags hold.
- REQ-025: On flag update: N = ex_result[WIDTH-1]; Z = (ex_result == 0) across all WIDTH bits.
- REQ-026: For ex_cntrl 010/011: C = ex_cout, V = ex_cout XOR ex_cin_msb; for subtraction, C=1 means no borrow.
- REQ-027: For ex_cntrl 100/101/110: C = 0, V = 0; for 000/111: C and V hold, N and Z update.
- REQ-028: flags_byp SHALL equal the values the flags will take at the next edge under REQ-024..027, and otherwise the current flag register.
- REQ-029: Simultaneous stall and flush: flush wins (REQ-022).

Reset
- REQ-030: reset_n=0 SHALL immediately, without waiting for clk, clear every output register (mem_*, flags) to 0.
- REQ-031: Reset asserted mid-stall or mid-flush SHALL override both; the first advance after reset_n rises loads normally.
- REQ-032: flags_byp SHALL read 0000 while in reset unless a flag update is pending on the inputs.

Verification
- REQ-033: Add setflags: ex_cntrl=010, ex_result=0, ex_cout=1, ex_cin_msb=1, ex_valid=1 -> after one edge flags N=0 Z=1 C=1 V=0; flags_byp shows 0110 in the cycle before the edge.
- REQ-034: Signed overflow: ex_cntrl=011, ex_result=0x8000_0000_0000_0000, ex_cout=0, ex_cin_msb=1 -> N=1 Z=0 C=0 V=1.
- REQ-035: Logic op: flags preset C=1 V=1, then ex_cntrl=100 with setflags and ex_result=0x1 -> N=0 Z=0 C=0 V=0.
- REQ-036: XZR write: ex_rd=31, ex_regwrite=1, ex_valid=1 -> mem_regwrite=0 and mem_rd=31.
- REQ-037: Stall then flush: load result 0x55, then stall=1 for 3 cycles with new inputs -> mem_result stays 0x55; then stall=1 and flush=1 together -> mem_valid=0, mem_result still 0x55, flags unchanged.
- REQ-038: Async reset: pulse reset_n low between clock edges while mem_valid=1 -> all outputs read 0 before the next edge.
